// File: rtl/tiny_mem_pkg.sv
// Shared types for the dual-channel wait-state memory model.
// FSM states, grant channel encoding, wait counter width, address helper.
package tiny_mem_pkg;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESP
    } state_t;

    typedef enum logic {
        FETCH,
        DATA
    } grant_t;

    localparam int CNT_W = 4;

    // Byte address to 32-bit word index; addr[1:0] is ignored.
    function automatic logic [29:0] word_index(input logic [31:0] addr);
        return addr[31:2];
    endfunction

endpackage

// File: rtl/tiny_mem_arbiter.sv
// Combinational arbiter between fetch and data requests.
// Ports: if_valid, d_valid, last_grant in; grant, grant_valid out.
import tiny_mem_pkg::*;

module tiny_mem_arbiter #(
    parameter int ARB_RR = 0
) (
    input  logic   if_valid,
    input  logic   d_valid,
    input  grant_t last_grant,
    output grant_t grant,
    output logic   grant_valid
);

    always_comb begin
        grant_valid = if_valid | d_valid;
        grant       = DATA;
        unique case (1'b1)
            (if_valid && !d_valid): grant = FETCH;
            // Contention: round-robin hands the slot to whoever
            // did not win last time, otherwise data wins.
            (if_valid && d_valid):
                grant = (ARB_RR != 0 && last_grant == DATA) ? FETCH : DATA;
            default: grant = DATA;
        endcase
    end

endmodule

// File: rtl/tiny_mem_dual_ws.sv
// Shared single-port memory serving a fetch and a data channel.
// Ports: clk, rst_n; if_* fetch req/resp; d_* data req/resp; busy.
import tiny_mem_pkg::*;

module tiny_mem_dual_ws #(
    parameter int    WORDS       = 4096,
    parameter string INIT_HEX    = "",
    parameter int    WAIT_STATES = 0,
    parameter int    ARB_RR      = 0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        if_valid,
    input  logic [31:0] if_addr,
    output logic        if_ready,
    output logic [31:0] if_rdata,
    output logic        if_err,
    input  logic        d_valid,
    input  logic        d_we,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    input  logic [3:0]  d_wstrb,
    output logic        d_ready,
    output logic [31:0] d_rdata,
    output logic        d_err,
    output logic        busy
);

    localparam int AW = (WORDS > 1) ? $clog2(WORDS) : 1;
    localparam logic [CNT_W-1:0] CNT_LOAD =
        (WAIT_STATES > 0) ? CNT_W'(WAIT_STATES - 1) : '0;

    logic [31:0] mem [WORDS];

    state_t           state;
    state_t           next_state;
    grant_t           last_grant;
    grant_t           gch;
    grant_t           grant;
    logic             grant_valid;
    logic [CNT_W-1:0] cnt;

    logic [31:0] acc_addr;
    logic        acc_we;
    logic [29:0] idx;
    logic        in_range;
    logic [AW-1:0] mem_idx;
    logic        accept;
    logic [31:0] rd_word;

    tiny_mem_arbiter #(
        .ARB_RR(ARB_RR)
    ) u_arb (
        .if_valid   (if_valid),
        .d_valid    (d_valid),
        .last_grant (last_grant),
        .grant      (grant),
        .grant_valid(grant_valid)
    );

    assign acc_addr = (grant == DATA) ? d_addr : if_addr;
    assign acc_we   = (grant == DATA) && d_we;
    assign idx      = word_index(acc_addr);
    assign in_range = {2'b00, idx} < 32'(WORDS);
    assign mem_idx  = idx[AW-1:0];
    assign accept   = (state == IDLE) && grant_valid;
    // Writes and out-of-range accesses both answer with zero data.
    assign rd_word  = (in_range && !acc_we) ? mem[mem_idx] : '0;

    always_comb begin
        next_state = state;
        unique case (state)
            IDLE: if (grant_valid)
                next_state = (WAIT_STATES > 0) ? WAIT : RESP;
            WAIT: if (cnt == '0) next_state = RESP;
            RESP: next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            last_grant <= FETCH;
            gch        <= FETCH;
            cnt        <= '0;
            if_rdata   <= '0;
            if_err     <= 1'b0;
            d_rdata    <= '0;
            d_err      <= 1'b0;
        end else begin
            state <= next_state;
            if (accept) begin
                last_grant <= grant;
                gch        <= grant;
                cnt        <= CNT_LOAD;
                if (grant == DATA) begin
                    d_rdata <= rd_word;
                    d_err   <= !in_range;
                end else begin
                    if_rdata <= rd_word;
                    if_err   <= !in_range;
                end
            end else if (state == WAIT && cnt != '0) begin
                cnt <= cnt - 1'b1;
            end
        end
    end

    // Array is never reset; writes commit at the accept edge so a
    // later request always observes them.
    always_ff @(posedge clk) begin
        if (rst_n && accept && acc_we && in_range) begin
            for (int b = 0; b < 4; b++) begin
                if (d_wstrb[b])
                    mem[mem_idx][8*b +: 8] <= d_wdata[8*b +: 8];
            end
        end
    end

    assign if_ready = (state == RESP) && (gch == FETCH);
    assign d_ready  = (state == RESP) && (gch == DATA);
    assign busy     = (state != IDLE);

endmodule

// File: tb/tb_tiny_mem_dual_ws.sv
// Scoreboard bench for tiny_mem_dual_ws across three configurations.
// Inst 0: WS=0 fixed prio; inst 1: WS=3 round-robin; inst 2: WS=5.
module tb_tiny_mem_dual_ws;

    localparam int N = 3;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    longint cyc = 0;

    logic        if_valid [N];
    logic [31:0] if_addr  [N];
    logic        if_ready [N];
    logic [31:0] if_rdata [N];
    logic        if_err   [N];
    logic        d_valid  [N];
    logic        d_we     [N];
    logic [31:0] d_addr   [N];
    logic [31:0] d_wdata  [N];
    logic [3:0]  d_wstrb  [N];
    logic        d_ready  [N];
    logic [31:0] d_rdata  [N];
    logic        d_err    [N];
    logic        busy     [N];

    typedef struct {
        int          inst;
        logic        ch;
        logic [31:0] rdata;
        logic        err;
        longint      cyc;
    } exp_t;

    exp_t   sb [$];
    int     checks = 0;
    int     errors = 0;
    longint busy_seen [N];

    function automatic int ws_of(int k);
        return (k == 0) ? 0 : ((k == 1) ? 3 : 5);
    endfunction

    for (genvar g = 0; g < N; g++) begin : g_dut
        tiny_mem_dual_ws #(
            .WORDS      (4096),
            .INIT_HEX   (""),
            .WAIT_STATES((g == 0) ? 0 : ((g == 1) ? 3 : 5)),
            .ARB_RR     ((g == 1) ? 1 : 0)
        ) u_dut (
            .clk     (clk),
            .rst_n   (rst_n),
            .if_valid(if_valid[g]),
            .if_addr (if_addr[g]),
            .if_ready(if_ready[g]),
            .if_rdata(if_rdata[g]),
            .if_err  (if_err[g]),
            .d_valid (d_valid[g]),
            .d_we    (d_we[g]),
            .d_addr  (d_addr[g]),
            .d_wdata (d_wdata[g]),
            .d_wstrb (d_wstrb[g]),
            .d_ready (d_ready[g]),
            .d_rdata (d_rdata[g]),
            .d_err   (d_err[g]),
            .busy    (busy[g])
        );
    end

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic void chk(string nm, logic [63:0] act, logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endfunction

    task automatic monitor_loop();
        exp_t e;
        forever begin
            @(negedge clk);
            for (int k = 0; k < N; k++) begin
                if (busy[k]) busy_seen[k]++;
                if (if_ready[k] || d_ready[k]) begin
                    if (sb.size() == 0) begin
                        chk($sformatf("unexpected_ready_i%0d", k), 1, 0);
                    end else begin
                        e = sb.pop_front();
                        chk("inst", 64'(k), 64'(e.inst));
                        chk("both_ready", {63'b0, if_ready[k] & d_ready[k]}, 0);
                        chk("channel", {63'b0, d_ready[k]}, {63'b0, e.ch});
                        chk("rdata", {32'b0, d_ready[k] ? d_rdata[k] : if_rdata[k]},
                            {32'b0, e.rdata});
                        chk("err", {63'b0, d_ready[k] ? d_err[k] : if_err[k]},
                            {63'b0, e.err});
                        chk("latency_cycle", cyc, e.cyc);
                    end
                end
            end
        end
    endtask

    // which: 0 fetch, 1 data, 2 either
    task automatic wait_ready(int k, int which);
        int n = 0;
        bit hit = 0;
        while (!hit && n < 60) begin
            @(negedge clk);
            n++;
            hit = (which == 0) ? if_ready[k] :
                  (which == 1) ? d_ready[k] : (if_ready[k] | d_ready[k]);
        end
        if (!hit) chk($sformatf("timeout_i%0d", k), 1, 0);
    endtask

    task automatic drive(int k, logic ch, logic we, logic [31:0] a,
                         logic [31:0] wd, logic [3:0] st);
        if (ch) begin
            d_valid[k] = 1'b1;
            d_we[k]    = we;
            d_addr[k]  = a;
            d_wdata[k] = wd;
            d_wstrb[k] = st;
        end else begin
            if_valid[k] = 1'b1;
            if_addr[k]  = a;
        end
    endtask

    task automatic push(int k, logic ch, logic [31:0] rd, logic er, longint at);
        exp_t e;
        e.inst = k; e.ch = ch; e.rdata = rd; e.err = er; e.cyc = at;
        sb.push_back(e);
    endtask

    task automatic xfer(int k, logic ch, logic we, logic [31:0] a,
                        logic [31:0] wd, logic [3:0] st,
                        logic [31:0] er, logic ee);
        drive(k, ch, we, a, wd, st);
        push(k, ch, er, ee, cyc + ws_of(k) + 1);
        wait_ready(k, ch ? 1 : 0);
        @(posedge clk); #1;
        if_valid[k] = 1'b0;
        d_valid[k]  = 1'b0;
    endtask

    function automatic logic [31:0] outs_of(int k);
        return {25'b0, busy[k], if_ready[k], d_ready[k], if_err[k], d_err[k],
                |if_rdata[k], |d_rdata[k]};
    endfunction

    // Start a request, then pull reset while it is still in flight.
    task automatic abort(int k, logic we, logic [31:0] a, logic [31:0] wd);
        drive(k, 1'b1, we, a, wd, 4'hF);
        repeat (3) @(posedge clk);
        #3 rst_n = 1'b0;
        #1 chk($sformatf("abort_outs_i%0d", k), {32'b0, outs_of(k)}, 0);
        chk("abort_rdata", {32'b0, d_rdata[k]}, 0);
        d_valid[k] = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (12) @(posedge clk);
        #1;
    endtask

    longint n0;
    longint b0;

    initial begin
        for (int k = 0; k < N; k++) begin
            if_valid[k] = 0; if_addr[k] = 0;
            d_valid[k] = 0; d_we[k] = 0; d_addr[k] = 0;
            d_wdata[k] = 0; d_wstrb[k] = 0;
            busy_seen[k] = 0;
        end
        fork monitor_loop(); join_none

        #1;
        for (int k = 0; k < N; k++)
            chk($sformatf("reset_outs_i%0d", k), {32'b0, outs_of(k)}, 0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk); #1;

        // WS=0 write then fetch of the same word.
        xfer(0, 1, 1, 32'h100, 32'hDEADBEEF, 4'hF, 32'h0, 0);
        xfer(0, 0, 0, 32'h100, 32'h0, 4'h0, 32'hDEADBEEF, 0);

        // WS=3 read latency and busy length.
        xfer(1, 1, 1, 32'h104, 32'h11223344, 4'hF, 32'h0, 0);
        b0 = busy_seen[1];
        xfer(1, 1, 0, 32'h104, 32'h0, 4'h0, 32'h11223344, 0);
        chk("busy_cycles", busy_seen[1] - b0, 4);

        // Partial strobes, no-op strobe, ignored low address bits.
        xfer(0, 1, 1, 32'h200, 32'h11223344, 4'hF, 32'h0, 0);
        xfer(0, 1, 1, 32'h200, 32'hAABBCCDD, 4'b0101, 32'h0, 0);
        xfer(0, 0, 0, 32'h200, 32'h0, 4'h0, 32'h11BB33DD, 0);
        xfer(0, 1, 1, 32'h200, 32'hFFFFFFFF, 4'h0, 32'h0, 0);
        xfer(0, 1, 0, 32'h203, 32'h0, 4'h0, 32'h11BB33DD, 0);

        // Out of range must not alias onto word 0.
        xfer(0, 1, 1, 32'h0, 32'h5A5A5A5A, 4'hF, 32'h0, 0);
        xfer(0, 1, 1, 32'h4000, 32'hFFFFFFFF, 4'hF, 32'h0, 1);
        xfer(0, 1, 0, 32'h0, 32'h0, 4'h0, 32'h5A5A5A5A, 0);
        xfer(0, 1, 0, 32'h4000, 32'h0, 4'h0, 32'h0, 1);
        xfer(0, 0, 0, 32'h4000, 32'h0, 4'h0, 32'h0, 1);
        xfer(0, 0, 0, 32'h3FFC, 32'h0, 4'h0, 32'h0, 0);

        // Fresh last_grant for the arbitration runs.
        rst_n = 1'b0;
        @(posedge clk); #1 rst_n = 1'b1;
        @(posedge clk); #1;

        // Fixed priority: data keeps winning while held.
        drive(0, 1, 0, 32'h100, 32'h0, 4'h0);
        drive(0, 0, 0, 32'h200, 32'h0, 4'h0);
        n0 = cyc;
        push(0, 1, 32'hDEADBEEF, 0, n0 + 1);
        push(0, 1, 32'hDEADBEEF, 0, n0 + 3);
        push(0, 1, 32'hDEADBEEF, 0, n0 + 5);
        push(0, 0, 32'h11BB33DD, 0, n0 + 7);
        repeat (3) wait_ready(0, 1);
        @(posedge clk); #1 d_valid[0] = 1'b0;
        wait_ready(0, 0);
        @(posedge clk); #1 if_valid[0] = 1'b0;

        // Round-robin: DATA, FETCH, DATA, FETCH.
        drive(1, 1, 0, 32'h104, 32'h0, 4'h0);
        drive(1, 0, 0, 32'h104, 32'h0, 4'h0);
        n0 = cyc;
        push(1, 1, 32'h11223344, 0, n0 + 4);
        push(1, 0, 32'h11223344, 0, n0 + 9);
        push(1, 1, 32'h11223344, 0, n0 + 14);
        push(1, 0, 32'h11223344, 0, n0 + 19);
        repeat (4) wait_ready(1, 2);
        @(posedge clk); #1;
        d_valid[1]  = 1'b0;
        if_valid[1] = 1'b0;

        // WS=5: reset during WAIT drops the transaction.
        xfer(2, 1, 1, 32'h300, 32'hCAFEF00D, 4'hF, 32'h0, 0);
        xfer(2, 1, 0, 32'h300, 32'h0, 4'h0, 32'hCAFEF00D, 0);
        abort(2, 0, 32'h300, 32'h0);
        xfer(2, 1, 0, 32'h300, 32'h0, 4'h0, 32'hCAFEF00D, 0);
        abort(2, 1, 32'h304, 32'h12345678);
        xfer(2, 0, 0, 32'h304, 32'h0, 4'h0, 32'h12345678, 0);

        repeat (4) @(posedge clk);
        chk("scoreboard_empty", 64'(sb.size()), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
